byte_to_word_rx: RTL and testbench
==================================

# byte_to_word_rx

Receive-side counterpart of the word/byte UART transmit path. It samples a UART serial line (8N1, LSB first) and has two modes, chosen per message. In byte mode (bypass) it delivers each received byte as it arrives. In word mode it assembles four consecutive bytes, least-significant byte first, into one 32-bit word. It sits between the board's serial RX pin and the consumer logic, and delivers each result with a single-cycle valid pulse.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per UART bit. Minimum 4.
- IDLE_TIMEOUT, default 1740: clock cycles allowed between the end of one byte's stop bit and the next byte's start edge, within a word.
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  receive enable. Low forces S_IDLE and discards any partial word. Output registers hold their values.
- i_mode_select  in  1  0 = byte (bypass) mode, 1 = word mode. Latched at each message's first start edge.
- i_serial  in  1  asynchronous UART line, idle high.
- o_word  out  32  last completed result. In byte mode: {24'h0, byte}.
- o_byte  out  8  last received byte. In word mode this is byte 3.
- o_valid  out  1  one-cycle pulse when o_word/o_byte are updated.
- o_frame_error  out  1  one-cycle pulse on a bad stop bit.
- o_timeout  out  1  one-cycle pulse when an inter-byte gap expires.
- o_state  out  3  current FSM state, for debug.

## Operation
- i_serial passes through a 2-flop synchronizer; both flops reset to 1. A falling edge means the synced sample is 0 and the previous synced sample was 1.
- FSM states (o_state encoding):
  - S_IDLE=0. On a falling edge with enable high: latch i_mode_select, set byte_idx=0, clear the bit counter, go to S_START.
  - S_START=1. Count to (CLKS_PER_BIT-1)/2. If the line is still 0, go to S_DATA with the counter cleared. If it is 1 (glitch), go back to the waiting state: S_IDLE if byte_idx=0, otherwise S_GAP with the gap timer continuing.
  - S_DATA=2. Every CLKS_PER_BIT cycles, sample one bit into shift[bit_idx]. bit_idx runs 0..7. After bit 7, go to S_STOP.
  - S_STOP=3. After CLKS_PER_BIT cycles, sample the line.
    - 1: go to S_STORE.
    - 0: pulse o_frame_error, discard the partial word, set byte_idx=0, go to S_IDLE.
  - S_STORE=4. Write shift into word_buf[8*byte_idx +: 8].
    - Byte mode, or byte_idx==3: go to S_DONE.
    - Otherwise: byte_idx+1, clear the gap timer, go to S_GAP.
  - S_DONE=5. Update o_word and o_byte, assert o_valid for this one cycle, then go to S_IDLE.
  - S_GAP=6. A falling edge goes to S_START, keeping the latched mode. If the gap timer reaches IDLE_TIMEOUT first: pulse o_timeout, set byte_idx=0, clear word_buf, go to S_IDLE.
  - Codes 7 and any other unused code go to S_IDLE.
- The mode is fixed for the whole message. Changes on i_mode_select between bytes of a word are ignored.
- Edge detection requires a 1→0 transition. A line held low (break) after a frame error does not retrigger until it returns high and falls again.
- Priority: reset > enable low > FSM transitions.
- Counters:
  - bit counter width is clog2(CLKS_PER_BIT).
  - gap timer width is clog2(IDLE_TIMEOUT+1). It saturates and does not wrap.
  - byte_idx is 2 bits. It never wraps, because S_STORE with byte_idx==3 always exits to S_DONE.

## Timing
- Reset values:
  - o_word=0, o_byte=0
  - o_valid=0, o_frame_error=0, o_timeout=0
  - o_state=S_IDLE
  - byte_idx=0, word_buf=0
- Reset during reception abandons the frame. The next valid falling edge after reset deasserts starts a new message.
- Latency:
  - The start edge is detected 2 cycles after the pin falls, because of the synchronizer.
  - Data bits are sampled at the bit midpoints.
  - o_valid rises 2 cycles after the stop-bit sample edge (S_STORE, then S_DONE).
- Output pulses are exactly 1 cycle and are never asserted together.
- o_word and o_byte are stable between o_valid pulses and are unaffected by errors, timeouts, or enable low.
- Back-to-back frames (next start bit directly after a stop bit) are received without loss: S_STORE, S_DONE and the return to idle take 2 cycles, which is less than the half-bit-period start check.

## Test plan
Run with CLKS_PER_BIT=8, IDLE_TIMEOUT=160.
- Byte mode, send 0xA5 → one o_valid pulse; o_byte=0xA5, o_word=0x000000A5; no error pulses.
- Word mode, send 0x78, 0x56, 0x34, 0x12 back-to-back → exactly one o_valid, after the 4th stop bit; o_word=0x12345678, o_byte=0x12. Toggle i_mode_select mid-word; the result must be unchanged.
- Word mode, 2nd byte sent with stop bit 0 → o_frame_error pulse, no o_valid. Then send 0xEF, 0xBE, 0xAD, 0xDE → o_word=0xDEADBEEF.
- Low glitch of 2 cycles on i_serial → o_state returns to S_IDLE, no pulses. Next byte 0x3C in byte mode → o_byte=0x3C.
- Word mode, 2 bytes then line idle for 160 cycles → one o_timeout pulse, o_word unchanged. The next full word is received correctly.
- Assert reset for 1 cycle mid-byte → all outputs 0, o_state=0. The following frame 0x5A in byte mode → o_byte=0x5A.

Source files
------------

// File: rtl/byte_to_word_rx.sv
`default_nettype none
// ============================================================================
//  Module   : byte_to_word_rx
//  Purpose  : UART 8N1 receiver delivering single bytes or LSB-first 32-bit
//             words, each completed result flagged by a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_to_word_rx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int IDLE_TIMEOUT = 1740
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        i_mode_select,
   input  logic        i_serial,
   output logic [31:0] o_word,
   output logic [7:0]  o_byte,
   output logic        o_valid,
   output logic        o_frame_error,
   output logic        o_timeout,
   output logic [2:0]  o_state
);

   localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
   localparam int                 c_gap_w     = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_half  = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
   localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_gap_w-1:0] c_gap_limit = c_gap_w'(IDLE_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_STORE = 3'd4,
      S_DONE  = 3'd5,
      S_GAP   = 3'd6
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 prev_q, prev_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [7:0]           shift_q, shift_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [31:0]          word_buf_q, word_buf_d;
   logic [c_gap_w-1:0]   gap_q, gap_d;
   logic                 mode_q, mode_d;
   logic [31:0]          word_q, word_d;
   logic [7:0]           byte_q, byte_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 tmo_q, tmo_d;
   logic                 w_fall_edge;

   assign w_fall_edge = prev_q & ~sync2_q;

   always_comb begin
      sync1_d    = i_serial;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      word_buf_d = word_buf_q;
      gap_d      = gap_q;
      mode_d     = mode_q;
      word_d     = word_q;
      byte_d     = byte_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      tmo_d      = 1'b0;

      if (!enable) begin
         state_d    = S_IDLE;
         byte_idx_d = 2'd0;
         word_buf_d = 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_fall_edge) begin
                  mode_d     = i_mode_select;
                  byte_idx_d = 2'd0;
                  cnt_d      = '0;
                  state_d    = S_START;
               end
            end
            S_START: begin
               // The inter-byte gap keeps running while a start bit is checked.
               if (gap_q != c_gap_limit) gap_d = gap_q + 1'b1;
               if (cnt_q == c_cnt_half) begin
                  cnt_d     = '0;
                  bit_idx_d = 3'd0;
                  if (!sync2_q)               state_d = S_DATA;
                  else if (byte_idx_q == 2'd0) state_d = S_IDLE;
                  else                        state_d = S_GAP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == c_cnt_last) begin
                  cnt_d              = '0;
                  shift_d[bit_idx_q] = sync2_q;
                  bit_idx_d          = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == c_cnt_last) begin
                  cnt_d = '0;
                  if (sync2_q) begin
                     state_d = S_STORE;
                  end else begin
                     ferr_d     = 1'b1;
                     byte_idx_d = 2'd0;
                     word_buf_d = 32'h0;
                     state_d    = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_STORE: begin
               word_buf_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
               if (!mode_q || byte_idx_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  gap_d      = '0;
                  state_d    = S_GAP;
               end
            end
            S_DONE: begin
               word_d     = mode_q ? word_buf_q : {24'h0, shift_q};
               byte_d     = shift_q;
               valid_d    = 1'b1;
               byte_idx_d = 2'd0;
               state_d    = S_IDLE;
            end
            S_GAP: begin
               if (w_fall_edge) begin
                  cnt_d   = '0;
                  state_d = S_START;
               end else if (gap_q >= c_gap_limit) begin
                  tmo_d      = 1'b1;
                  byte_idx_d = 2'd0;
                  word_buf_d = 32'h0;
                  state_d    = S_IDLE;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         cnt_q      <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h0;
         byte_idx_q <= 2'd0;
         word_buf_q <= 32'h0;
         gap_q      <= '0;
         mode_q     <= 1'b0;
         word_q     <= 32'h0;
         byte_q     <= 8'h0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         word_buf_q <= word_buf_d;
         gap_q      <= gap_d;
         mode_q     <= mode_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         tmo_q      <= tmo_d;
      end
   end

   assign o_word        = word_q;
   assign o_byte        = byte_q;
   assign o_valid       = valid_q;
   assign o_frame_error = ferr_q;
   assign o_timeout     = tmo_q;
   assign o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_to_word_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_to_word_rx
//  Purpose  : Directed and random serial traffic against byte_to_word_rx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_to_word_rx;

   localparam int CPB = 8;
   localparam int TMO = 160;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        i_mode_select = 1'b0;
   logic        i_serial = 1'b1;
   logic [31:0] o_word;
   logic [7:0]  o_byte;
   logic        o_valid, o_frame_error, o_timeout;
   logic [2:0]  o_state;

   always #5 clock = ~clock;

   byte_to_word_rx #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .i_mode_select(i_mode_select), .i_serial(i_serial),
      .o_word(o_word), .o_byte(o_byte), .o_valid(o_valid),
      .o_frame_error(o_frame_error), .o_timeout(o_timeout), .o_state(o_state)
   );

   int tests = 0;
   int fails = 0;

   // Pulse observer: counts events and tracks pulse width, overlap and stability.
   int          n_valid = 0, n_ferr = 0, n_tmo = 0;
   int          n_long = 0, n_overlap = 0, n_unstable = 0;
   logic        prev_v = 1'b0, prev_f = 1'b0, prev_t = 1'b0, prev_rst = 1'b1;
   logic [31:0] prev_word = 32'h0;
   logic [7:0]  prev_byte = 8'h0;

   always @(negedge clock) begin
      if (o_valid)       n_valid++;
      if (o_frame_error) n_ferr++;
      if (o_timeout)     n_tmo++;
      if ((o_valid && prev_v) || (o_frame_error && prev_f) || (o_timeout && prev_t)) n_long++;
      if (int'(o_valid) + int'(o_frame_error) + int'(o_timeout) > 1) n_overlap++;
      if (!o_valid && !reset && !prev_rst && (o_word !== prev_word || o_byte !== prev_byte))
         n_unstable++;
      prev_v    = o_valid;
      prev_f    = o_frame_error;
      prev_t    = o_timeout;
      prev_rst  = reset;
      prev_word = o_word;
      prev_byte = o_byte;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      i_serial = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      i_serial = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         i_serial = b[i];
         repeat (CPB) @(negedge clock);
      end
      i_serial = stop;
      repeat (CPB) @(negedge clock);
      i_serial = 1'b1;
   endtask

   // Sends one message; in word mode the select line may flip after every byte.
   task automatic send_msg(input logic word_mode, input logic [31:0] data, input logic toggle);
      i_mode_select = word_mode;
      if (word_mode) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(data[8*k +: 8], 1'b1);
            if (toggle) i_mode_select = ~i_mode_select;
         end
      end else begin
         send_byte(data[7:0], 1'b1);
      end
      idle(6);
   endtask

   // Reference: a word is its four bytes LSB first; a byte is zero-extended.
   task automatic send_and_check(input string tag, input logic word_mode,
                                 input logic [31:0] data, input logic toggle);
      int v0, f0, t0;
      logic [31:0] exp_word;
      logic [7:0]  exp_byte;
      v0 = n_valid; f0 = n_ferr; t0 = n_tmo;
      exp_word = word_mode ? data : {24'h0, data[7:0]};
      exp_byte = word_mode ? data[31:24] : data[7:0];
      send_msg(word_mode, data, toggle);
      check({tag, ".valid_count"}, 32'(n_valid - v0), 32'd1);
      check({tag, ".word"}, o_word, exp_word);
      check({tag, ".byte"}, {24'h0, o_byte}, {24'h0, exp_byte});
      check({tag, ".err_pulses"}, 32'((n_ferr - f0) + (n_tmo - t0)), 32'd0);
   endtask

   initial begin
      int v0, f0, t0;
      logic [31:0] rnd;
      logic [31:0] held;

      repeat (3) @(negedge clock);
      check("reset.word", o_word, 32'h0);
      check("reset.byte", {24'h0, o_byte}, 32'h0);
      check("reset.pulses", {29'h0, o_valid, o_frame_error, o_timeout}, 32'h0);
      check("reset.state", {29'h0, o_state}, 32'h0);
      reset  = 1'b0;
      enable = 1'b1;
      idle(10);

      send_and_check("byte_a5", 1'b0, 32'h000000A5, 1'b0);
      send_and_check("word_toggle", 1'b1, 32'h12345678, 1'b1);

      // Second byte of a word carries a bad stop bit.
      v0 = n_valid; f0 = n_ferr;
      i_mode_select = 1'b1;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      idle(20);
      check("ferr.count", 32'(n_ferr - f0), 32'd1);
      check("ferr.no_valid", 32'(n_valid - v0), 32'd0);
      check("ferr.word_held", o_word, 32'h12345678);
      send_and_check("word_deadbeef", 1'b1, 32'hDEADBEEF, 1'b0);

      // Two-cycle low glitch on an idle line.
      v0 = n_valid; f0 = n_ferr; t0 = n_tmo;
      i_serial = 1'b0;
      repeat (2) @(negedge clock);
      idle(20);
      check("glitch.state", {29'h0, o_state}, 32'h0);
      check("glitch.pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_tmo - t0)), 32'd0);
      send_and_check("byte_3c", 1'b0, 32'h0000003C, 1'b0);

      // Word abandoned after two bytes: gap expires.
      v0 = n_valid; t0 = n_tmo;
      i_mode_select = 1'b1;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      idle(TMO + 40);
      check("tmo.count", 32'(n_tmo - t0), 32'd1);
      check("tmo.no_valid", 32'(n_valid - v0), 32'd0);
      check("tmo.word_held", o_word, 32'h0000003C);
      rnd = $urandom;
      send_and_check("tmo.next_word", 1'b1, rnd, 1'b0);

      // Reset in the middle of a frame.
      i_mode_select = 1'b0;
      i_serial = 1'b0;
      repeat (3 * CPB) @(negedge clock);
      reset    = 1'b1;
      i_serial = 1'b1;
      @(negedge clock);
      check("midreset.word", o_word, 32'h0);
      check("midreset.byte", {24'h0, o_byte}, 32'h0);
      check("midreset.state", {29'h0, o_state}, 32'h0);
      check("midreset.pulses", {29'h0, o_valid, o_frame_error, o_timeout}, 32'h0);
      reset = 1'b0;
      idle(20);
      send_and_check("byte_5a", 1'b0, 32'h0000005A, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rnd = {24'h0, 8'($urandom)};
         send_and_check("rand_byte", 1'b0, rnd, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         rnd = $urandom;
         send_and_check("rand_word", 1'b1, rnd, 1'($urandom_range(0, 1)));
      end

      // Enable dropped mid-word discards the partial word.
      held = o_word;
      v0 = n_valid;
      i_mode_select = 1'b1;
      send_byte(8'h77, 1'b1);
      enable = 1'b0;
      idle(5);
      enable = 1'b1;
      idle(5);
      check("enable_low.no_valid", 32'(n_valid - v0), 32'd0);
      check("enable_low.word_held", o_word, held);
      send_and_check("after_enable", 1'b1, 32'hCAFEF00D, 1'b0);

      check("pulse_width", 32'(n_long), 32'd0);
      check("pulse_overlap", 32'(n_overlap), 32'd0);
      check("output_stability", 32'(n_unstable), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
